wb_port_arbiter: RTL
====================

# wb_port_arbiter

Shares the single integer register-file write port between the in-order pipeline writeback result (the writeback-select output) and results returned by the multi-cycle multiply/divide unit. MDU results are buffered in a small FIFO and drained when the pipeline leaves the port idle, or forcibly after a bounded wait, stalling the pipeline writeback for that cycle. The block sits between the writeback stage and the register file and registers the write port.

## Interface

- `DEPTH`, 2: MDU result FIFO entries, power of two, ≥2.
- `STARVE_LIMIT`, 4: consecutive cycles a non-empty FIFO may lose arbitration before it is forced, 1–15.

Ports:

- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `pipe_valid`  in  1  writeback stage presents a register write this cycle.
- `pipe_rd`  in  5  destination register of the pipeline write.
- `pipe_data`  in  64  pipeline write data (writeback-select result).
- `pipe_stall`  out  1  pipeline write not taken this cycle; writeback stage must hold its `pipe_*` inputs.
- `mdu_valid`  in  1  MDU presents a completed result.
- `mdu_rd`  in  5  MDU destination register.
- `mdu_data`  in  64  MDU result.
- `mdu_ready`  out  1  FIFO can accept; transfer when `mdu_valid & mdu_ready`.
- `rf_we`  out  1  registered register-file write enable.
- `rf_waddr`  out  5  registered write address.
- `rf_wdata`  out  64  registered write data.

## Operation

- FIFO: `DEPTH` entries of {rd, data}; read/write pointers wrap modulo `DEPTH`; separate count 0..DEPTH.
- Enqueue on `mdu_valid & mdu_ready` when `mdu_rd != 0`. An accepted transfer with `mdu_rd == 0` is consumed and discarded; FIFO unchanged.
- `mdu_ready = (count < DEPTH)`; it depends on registered count only, so a full FIFO refuses even in a dequeue cycle.
- Grant per cycle, with `fe = (count != 0)`:
  - FIFO grant if `fe & (!pipe_valid | starve_cnt == STARVE_LIMIT)`.
  - Pipe grant if `pipe_valid` and no FIFO grant.
  - Idle otherwise.
- `pipe_stall = pipe_valid & FIFO grant`.
- FIFO grant: dequeue head; next `rf_we=1`, `rf_waddr`/`rf_wdata` = head.
- Pipe grant: next `rf_we = (pipe_rd != 0)`, `rf_waddr=pipe_rd`, `rf_wdata=pipe_data`.
- Idle: next `rf_we=0`. `rf_waddr`/`rf_wdata` hold their previous values.
- `starve_cnt` (4 bits):
  - Increments on a cycle with `fe` and a pipe grant; saturates at `STARVE_LIMIT`.
  - Clears on a FIFO grant, or whenever `fe == 0`.
- Simultaneous enqueue and dequeue: count unchanged and both pointers advance. The entry just enqueued cannot be granted in its enqueue cycle; there is no bypass.
- WAW ordering between a buffered MDU result and a later pipeline write to the same rd is guaranteed upstream by the scoreboard and is not checked here.

## Timing

- Reset (async assert, synchronous-to-`clk` deassert by the reset tree):
  - count, pointers and `starve_cnt` = 0.
  - `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`.
  - `mdu_ready=1`; `pipe_stall=0`.
- Reset mid-operation flushes all buffered MDU results. The MDU is reset alongside.
- Latency:
  - Pipe grant to `rf_we` visible: 1 cycle.
  - MDU handshake to earliest `rf_we`: 2 cycles (enqueue edge, then grant edge).
- `pipe_stall` and the grant are combinational from `pipe_valid` and registered state. There is no path from `mdu_valid` to `pipe_stall` or to `mdu_ready`.
- Worst-case MDU wait with the pipe continuously valid: `STARVE_LIMIT` pipe grants, then a forced FIFO grant.
- Throughput: one register-file write per cycle maximum.

## Test plan

- Idle port, MDU result: `mdu_valid=1`, rd=5, data=0xDEAD for one cycle, `pipe_valid=0`. Expect `mdu_ready=1`, then `rf_we=1`, waddr=5, wdata=0xDEAD two cycles after the handshake, and no `pipe_stall`.
- Starvation: one MDU result (rd=7) buffered while `pipe_valid=1` continuously with rd=1..N. Expect 4 pipe writes, then 1 cycle of `pipe_stall=1` with rd=7 written, then the held pipe write lands next.
- Full FIFO: 3 back-to-back MDU results (rd 2, 3, 4) with `pipe_valid=1` and `STARVE_LIMIT=4`. Expect `mdu_ready=0` after 2 accepts, and the third accepted only after the first forced drain. Order is preserved (2, 3, 4).
- x0 discard: pipe write rd=0 gives `rf_we=0` and `pipe_stall=0`. MDU result rd=0 gives a handshake, count stays 0, and no write occurs.
- Reset mid-operation: 2 MDU entries buffered, `resetn` pulsed low between edges. Expect outputs zero immediately, `mdu_ready=1`, and no stale writes after release.
- Simultaneous enqueue/dequeue at count=1, pipe idle: expect count to stay 1, pointers to wrap correctly over 8 iterations, and writes in arrival order.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline writeback and buffered MDU results
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [63:0] pipe_data,
  output logic        pipe_stall,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [63:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    rdMem   [DEPTH];
  logic [63:0]   dataMem [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count;
  logic [3:0]    starveCnt;
  logic          fe, fifoGrant, pipeGrant, enq;

  // grant decision depends only on pipe_valid and registered state, never on mdu_valid
  always_comb begin
    fe         = count != '0;
    fifoGrant  = fe & (!pipe_valid | starveCnt == 4'(STARVE_LIMIT));
    pipeGrant  = pipe_valid & !fifoGrant;
    pipe_stall = pipe_valid & fifoGrant;
    mdu_ready  = count < CW'(DEPTH);
    enq        = mdu_valid & mdu_ready & (mdu_rd != 5'd0);
  end

  // result storage; writes to x0 are dropped before reaching it
  always_ff @(posedge clk) begin
    if (enq) begin
      rdMem[wrPtr]   <= mdu_rd;
      dataMem[wrPtr] <= mdu_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (enq) wrPtr <= wrPtr + 1'b1;
      if (fifoGrant) rdPtr <= rdPtr + 1'b1;
      if (enq & !fifoGrant) count <= count + CW'(1);
      else if (!enq & fifoGrant) count <= count - CW'(1);
    end
  end

  // counts how long a waiting MDU result has lost to the pipeline, saturating at the limit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) starveCnt <= '0;
    else if (!fe | fifoGrant) starveCnt <= '0;
    else if (pipeGrant & starveCnt != 4'(STARVE_LIMIT)) starveCnt <= starveCnt + 4'd1;
  end

  // registered write port; address and data hold when the port is idle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (fifoGrant) begin
      rf_we    <= 1'b1;
      rf_waddr <= rdMem[rdPtr];
      rf_wdata <= dataMem[rdPtr];
    end else if (pipeGrant) begin
      rf_we    <= pipe_rd != 5'd0;
      rf_waddr <= pipe_rd;
      rf_wdata <= pipe_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end
endmodule
